// File: rtl/dnn_pkg.sv
// Shared constants, state encoding and zero-skip helper functions for the
// sequenced 4-4-2 MLP controller.
package dnn_pkg;

    localparam int unsigned DW = 5;    // input / weight width (signed)
    localparam int unsigned HW = 12;   // hidden value width (signed)
    localparam int unsigned OW = 17;   // output accumulator width (signed)

    localparam int unsigned NI = 4;    // inputs
    localparam int unsigned NH = 4;    // hidden neurons
    localparam int unsigned NO = 2;    // outputs

    localparam int unsigned IW = 2;    // loop counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        L1   = 2'd1,
        L2   = 2'd2,
        DONE = 2'd3
    } state_t;

    // Index of the lowest set bit of m (0 when m is empty).
    function automatic logic [IW-1:0] lowest_set(input logic [NH-1:0] m);
        lowest_set = '0;
        for (int k = NH - 1; k >= 0; k--) begin
            if (m[k]) lowest_set = IW'(k);
        end
    endfunction

    // Bits of m strictly above position idx.
    function automatic logic [NH-1:0] mask_above(input logic [NH-1:0] m,
                                                 input logic [IW-1:0] idx);
        mask_above = '0;
        for (int k = 0; k < NH; k++) begin
            if (IW'(k) > idx) mask_above[k] = m[k];
        end
    endfunction

endpackage

// File: rtl/dnn_mac.sv
// Signed multiply-accumulate. The running sum restarts from zero when
// 'first' is high, so a new dot product needs no separate clear cycle.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   en         : update the accumulator with sum_c this edge
//   first      : ignore the stored accumulator (first term of a sum)
//   a, b       : signed operands (AW, BW bits)
//   sum_c      : combinational accumulator + sign-extended product (SW bits)
module dnn_mac #(
    parameter int unsigned AW = 12,
    parameter int unsigned BW = 5,
    parameter int unsigned SW = 17
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 first,
    input  logic signed [AW-1:0] a,
    input  logic signed [BW-1:0] b,
    output logic signed [SW-1:0] sum_c
);

    localparam int unsigned PW = AW + BW;

    logic signed [SW-1:0] acc;
    logic signed [PW-1:0] prod;
    logic signed [SW-1:0] base;

    // Full-precision product, then sign-extended into the accumulator width.
    always_comb begin
        prod  = PW'(a) * PW'(b);
        base  = first ? '0 : acc;
        sum_c = base + SW'(prod);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum_c;
        end
    end

endmodule

// File: rtl/dnn_seq_ctrl.sv
// Sequenced 4-4-2 MLP: layer1 4x4 MAC + ReLU, then layer3 4x2 MAC, all on
// one time-multiplexed signed MAC. One job is taken through a valid/ready
// input handshake and results are offered through a valid/ready output.
// Optional build macro: DNN_ZERO_SKIP_EN -- layer3 visits only nonzero
// hidden values (ascending), shortening latency to 16+2*NZ edges.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : job handshake (in_ready high only in IDLE)
//   x_in, w1_in, w2_in  : packed inputs and weights, latched on accept
//   out_valid/out_ready : result handshake
//   out0, out1          : signed results
//   busy                : job in progress or result pending
module dnn_seq_ctrl
    import dnn_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NI*DW-1:0]      x_in,
    input  logic [NH*NI*DW-1:0]   w1_in,
    input  logic [NO*NH*DW-1:0]   w2_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [OW-1:0]  out0,
    output logic signed [OW-1:0]  out1,
    output logic                  busy
);

    state_t state, state_next;

    logic [NI*DW-1:0]     x_r;
    logic [NH*NI*DW-1:0]  w1_r;
    logic [NO*NH*DW-1:0]  w2_r;
    logic signed [HW-1:0] hidden [NH];

    // outer = h (L1) / o (L2), inner = i (L1) / j (L2)
    logic [IW-1:0] outer, outer_next;
    logic [IW-1:0] inner, inner_next;

    logic                 accept_c;
    logic                 mac_en_c;
    logic                 mac_first_c;
    logic signed [HW-1:0] mac_a_c;
    logic signed [DW-1:0] mac_b_c;
    logic signed [OW-1:0] sum_c;
    logic signed [HW-1:0] relu_c;
    logic                 hid_wr_c;
    logic                 out_wr_c;
    logic                 zero_out_c;

    // Layer3 index sequencing: first/last term, successor, and start index.
    logic          l2_first_c;
    logic          l2_last_c;
    logic [IW-1:0] l2_next_c;
    logic [IW-1:0] l2_start_c;
    logic          skip_all_c;

    dnn_mac #(
        .AW (HW),
        .BW (DW),
        .SW (OW)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (mac_en_c),
        .first (mac_first_c),
        .a     (mac_a_c),
        .b     (mac_b_c),
        .sum_c (sum_c)
    );

    // Layer1 sums are at most 1024 in magnitude, so the low HW bits are exact.
    assign relu_c = sum_c[OW-1] ? '0 : sum_c[HW-1:0];

`ifdef DNN_ZERO_SKIP_EN
    logic [NH-1:0] nz_c;
    logic [NH-1:0] above_c;

    // Nonzero map; during L1 the entry being written this edge uses relu_c so
    // the start index is correct on the L1 -> L2 transition.
    always_comb begin
        nz_c = '0;
        for (int k = 0; k < NH; k++) begin
            if ((state == L1) && (IW'(k) == outer)) nz_c[k] = (relu_c != '0);
            else                                   nz_c[k] = (hidden[k] != '0);
        end
    end

    assign above_c    = mask_above(nz_c, inner);
    assign l2_start_c = lowest_set(nz_c);
    assign l2_first_c = (inner == l2_start_c);
    assign l2_last_c  = (above_c == '0);
    assign l2_next_c  = lowest_set(above_c);
    assign skip_all_c = (nz_c == '0);
`else
    assign l2_start_c = '0;
    assign l2_first_c = (inner == '0);
    assign l2_last_c  = (inner == IW'(NH - 1));
    assign l2_next_c  = inner + IW'(1);
    assign skip_all_c = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, counter sequencing and MAC operand selection.
    always_comb begin
        state_next  = state;
        outer_next  = outer;
        inner_next  = inner;
        accept_c    = 1'b0;
        mac_en_c    = 1'b0;
        mac_first_c = 1'b0;
        mac_a_c     = '0;
        mac_b_c     = '0;
        hid_wr_c    = 1'b0;
        out_wr_c    = 1'b0;
        zero_out_c  = 1'b0;

        unique case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept_c   = 1'b1;
                    outer_next = '0;
                    inner_next = '0;
                    state_next = L1;
                end
            end

            L1: begin
                mac_en_c    = 1'b1;
                mac_first_c = (inner == '0);
                mac_a_c     = HW'($signed(x_r[DW*32'(inner) +: DW]));
                mac_b_c     = w1_r[DW*32'({outer, inner}) +: DW];
                inner_next  = inner + IW'(1);
                if (inner == IW'(NI - 1)) begin
                    hid_wr_c = 1'b1;
                    if (outer == IW'(NH - 1)) begin
                        outer_next = '0;
                        inner_next = l2_start_c;
                        if (skip_all_c) begin
                            zero_out_c = 1'b1;
                            state_next = DONE;
                        end else begin
                            state_next = L2;
                        end
                    end else begin
                        outer_next = outer + IW'(1);
                    end
                end
            end

            L2: begin
                mac_en_c    = 1'b1;
                mac_first_c = l2_first_c;
                mac_a_c     = hidden[inner];
                mac_b_c     = w2_r[DW*32'({outer[0], inner}) +: DW];
                if (l2_last_c) begin
                    out_wr_c   = 1'b1;
                    inner_next = l2_start_c;
                    if (outer == IW'(NO - 1)) begin
                        outer_next = '0;
                        state_next = DONE;
                    end else begin
                        outer_next = outer + IW'(1);
                    end
                end else begin
                    inner_next = l2_next_c;
                end
            end

            DONE: begin
                if (out_ready) state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

    // Datapath registers and registered handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r       <= '0;
            w1_r      <= '0;
            w2_r      <= '0;
            for (int k = 0; k < NH; k++) hidden[k] <= '0;
            outer     <= '0;
            inner     <= '0;
            out0      <= '0;
            out1      <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            outer <= outer_next;
            inner <= inner_next;
            if (accept_c) begin
                x_r  <= x_in;
                w1_r <= w1_in;
                w2_r <= w2_in;
            end
            if (hid_wr_c) hidden[outer] <= relu_c;
            if (out_wr_c) begin
                if (outer == '0) out0 <= sum_c;
                else             out1 <= sum_c;
            end
            if (zero_out_c) begin
                out0 <= '0;
                out1 <= '0;
            end
            in_ready  <= (state_next == IDLE);
            busy      <= (state_next != IDLE);
            out_valid <= (state_next == DONE);
        end
    end

endmodule

// File: doc/dnn_seq_ctrl.md
Name: dnn_seq_ctrl

Overview:
Sequenced controller and datapath for the 4-4-2 MLP: layer1 4x4 MAC, ReLU, layer3 4x2 MAC.
- One shared signed MAC is time-multiplexed, replacing 24 parallel multipliers.
- Takes one inference job through a valid/ready input handshake.
- Steps 16 layer1 MACs and then 8 output MACs.
- Presents out0/out1 through a valid/ready output handshake.

Parameters:
DW, 5, signed width of each input and weight
HW, 12, signed width of hidden accumulator and ReLU result
OW, 17, signed width of output accumulator and out0/out1

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous reset, active-low
in_valid  in  1  job offered
in_ready  out  1  high only in IDLE
x_in  in  4*DW  x_i = x_in[DW*i +: DW]
w1_in  in  16*DW  weight input i->hidden h = w1_in[DW*(4*h+i) +: DW]
w2_in  in  8*DW  weight hidden j->output o = w2_in[DW*(4*o+j) +: DW]
out_valid  out  1  results valid
out_ready  in  1  consumer accepts
out0  out  OW  signed output 0
out1  out  OW  signed output 1
busy  out  1  high in L1, L2 and DONE

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out0=out1=0; all operand, hidden and accumulator registers 0.
- Reset asserted mid-job aborts immediately; no partial result is ever flagged valid.
- FSM: IDLE -> L1 -> L2 -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready (the accept edge, edge 0), latch x_in, w1_in, w2_in into local registers, clear counters, go to L1.
  - Inputs are ignored at every other time.
- L1: 16 edges, counter h(0..3) outer, i(0..3) inner.
  - Each edge: acc = (i==0 ? 0 : acc) + x_i*w1[h][i].
  - Product is DW x DW = 10-bit signed, sign-extended to HW.
  - At i==3: hidden[h] = (sum<0) ? 0 : sum. Worst case 4*256=1024 fits HW; no saturation needed.
  - After h=3,i=3, go to L2.
- L2: 8 edges, counter o(0..1) outer, j(0..3) inner.
  - Each edge: acc = (j==0 ? 0 : acc) + hidden[j]*w2[o][j], sign-extended to OW.
  - Range is -65536..61440, which fits 17-bit signed exactly.
  - At j==3, the sum is written to out0 (o=0) or out1 (o=1).
  - After o=1,j=3, go to DONE.
- DONE:
  - out_valid=1; out0/out1 stable.
  - On out_valid&&out_ready: out_valid falls and state returns to IDLE; in_ready rises the following cycle.
  - A new job cannot be accepted in the same cycle as the output handshake.
- Latency: out_valid is high after edge 24 counted from the accept edge.
  - Throughput: one job per 26 cycles when out_ready is held high.
- Backpressure: out_ready low holds DONE indefinitely with outputs unchanged.
- out0/out1 retain their values after the handshake until overwritten by the next job's L2; they are meaningful only while out_valid=1.

Optional Feature:
Macro DNN_ZERO_SKIP_EN.
- Defined: L2 visits only hidden indices j with hidden[j]!=0, in ascending order, via a priority encoder; the same set is used for both outputs.
  - L2 takes 2*NZ edges, NZ = count of nonzero hidden values.
  - out_valid is high after edge 16+2*NZ.
  - If NZ==0: L2 is skipped, out0=out1=0 are written, DONE is reached after edge 16.
- Undefined: fixed 8-edge L2 and fixed latency 24.
- Numerical results are identical either way.

Decomposition:
- Package dnn_pkg: DW/HW/OW, NI=4, NH=4, NO=2 constants; state enum {IDLE,L1,L2,DONE}; index widths.
- Sub-module dnn_mac: signed multiply-accumulate with clear-on-first-term and a sign-extension width parameter.
  - Instantiated once; the controller muxes its operands.

Test Plan:
- All x=1, w1=1, w2=1 -> hidden=4 each; out0=out1=16; out_valid after edge 24 (16 with zero-skip disabled path check: 24 regardless, since NZ=4 gives 16+8).
- x=-16, w1=-16, w2=-16 -> hidden=1024; out0=out1=-65536 (17'h10000). Repeat with w2=15 -> 61440.
- x=[1,2,3,4]; w1 rows h0=[1,1,1,1], h1=[-1,-1,-1,-1], h2=[2,0,0,0], h3=[0,0,0,-3] -> hidden=[10,0,2,0].
  - w2 o0=[1,1,1,1], o1=[3,-2,-5,7] -> out0=12, out1=20.
  - out_valid after edge 24, or edge 20 with DNN_ZERO_SKIP_EN.
- x=1, w1=-1 -> all hidden 0 -> out0=out1=0; out_valid after edge 24, or edge 16 with DNN_ZERO_SKIP_EN.
- out_ready held low 10 cycles in DONE -> out_valid, out0, out1 stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
- rst_n low at edge 8 of L1, then a fresh job -> out_valid=0 and in_ready=1 immediately on reset; the new job's result is correct with no residue from the aborted job.
